mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage initiator for the word-addressed data RAM.
- Converts pipeline load/store requests (byte, half, word; signed and unsigned loads) into RAM word accesses.
- The RAM writes whole words only, so byte and half stores use read-modify-write (RMW).
- Stalls the pipeline through a ready/valid pair and flags misaligned accesses instead of performing them.

Parameters:
- ADDR_W, 32, byte-address width on both sides.
- DATA_W, 32, data width; the lane logic is fixed to 4 byte lanes.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid_i  in  1  pipeline request present.
- req_ready_o  out  1  unit idle and able to accept a request.
- req_we_i  in  1  1 = store, 0 = load.
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned_i  in  1  zero-extend the load result (LBU/LHU).
- req_addr_i  in  32  byte address.
- req_wdata_i  in  32  store data, right-aligned.
- rsp_valid_o  out  1  one-cycle completion pulse (load data or store ack).
- rsp_rdata_o  out  32  extended load data; 0 for stores and errors.
- rsp_misalign_o  out  1  qualifies rsp_valid_o: access rejected.
- ram_we_o  out  1  RAM write enable.
- ram_addr_o  out  32  RAM byte address, bits [1:0] always 00.
- ram_wdata_o  out  32  RAM write word.
- ram_rdata_i  in  32  RAM combinational read data.

Behaviour:
- Reset is asynchronous.
  - State goes to IDLE.
  - All registers clear: rsp_valid_o=0, rsp_rdata_o=0, rsp_misalign_o=0.
  - ram_we_o=0 and ram_addr_o=0, since both decode from state and registers.
- States are IDLE, ACCESS, WRITE and ERR.
- req_ready_o = (state==IDLE). A request is accepted on a clock edge with req_valid_i && req_ready_o.
- On accept, the unit registers we, size, unsigned, addr, wdata and a misalign flag.
  - Misaligned when: size=01 with addr[0]=1; size=10 with addr[1:0]!=00; or size=11.
  - Misaligned requests go to ERR; all others go to ACCESS.
- ACCESS state:
  - ram_addr_o = {addr[31:2],2'b00}.
  - Load: on the next edge, capture the lane-extracted ram_rdata_i into rsp_rdata_o, pulse rsp_valid_o, and return to IDLE.
  - Word store: ram_we_o=1 and ram_wdata_o=wdata; on the next edge, pulse the ack and return to IDLE.
  - Byte or half store: ram_we_o=0; on the next edge, latch the merged word (ram_rdata_i with the addressed lanes replaced) and go to WRITE.
- WRITE state: ram_we_o=1 and ram_wdata_o=merged word; on the next edge, pulse the ack and return to IDLE.
- ERR state: no RAM access; on the next edge, pulse rsp_valid_o with rsp_misalign_o=1 and rsp_rdata_o=0, and return to IDLE.
- Lane mapping is little-endian: byte k occupies bits [8k+7:8k], and a half uses lanes {addr[1],0}.
  - Signed loads sign-extend from bit 7 or bit 15.
- Latency from the accept edge to the cycle in which rsp_valid_o is high:
  - Load or word store: 2 cycles.
  - Byte or half store: 3 cycles.
  - Misaligned access: 2 cycles.
- rsp_valid_o is high for exactly one cycle, with no backpressure.
- req_ready_o returns to 1 in the same cycle that rsp_valid_o is high, so back-to-back requests are allowed.
- ram_we_o is high for at most one cycle per store and never for a load or an error.
- Requests arriving while req_ready_o=0 are ignored. The pipeline must hold req_valid_i and the request fields until accepted.
- Reset asserted in any state takes effect immediately: an in-flight RMW is abandoned, no write occurs, and no response is issued.

Decomposition:
- Shared package mem_pkg holds:
  - size encodings (MEM_BYTE, MEM_HALF, MEM_WORD);
  - the state enumeration;
  - the function computing misalignment from size and addr[1:0].
- Sub-module mem_lane_align is purely combinational and has two parts:
  - load extract/extend (word, addr[1:0], size, unsigned -> 32-bit result);
  - store merge (old word, new data, addr[1:0], size -> merged word).
- The FSM and registers stay in mem_access_unit.

Test Plan:
- Word load: RAM word at 0x0001_0000 = 0x00626261; LW 0x0001_0000 -> rsp_valid high in cycle 2 after accept, rsp_rdata=0x00626261, misalign=0, ram_we never 1.
- Sign-extending loads: word at 0x100 = 0x8061_7F62.
  - LB 0x103 -> 0xFFFFFF80.
  - LBU 0x103 -> 0x00000080.
  - LH 0x102 -> 0xFFFF8061.
  - LHU 0x100 -> 0x00007F62.
- Sub-word stores over word 0x11223344 at 0x200:
  - SB 0x201 data 0x000000AB -> a single ram_we pulse in WRITE with ram_wdata=0x1122AB44; ack in cycle 3; reload reads 0x1122AB44.
  - SH 0x202 data 0x5566 -> 0x55663344.
- Misaligned: LW 0x102 and SH 0x203 -> rsp_valid in cycle 2 with misalign=1, rdata=0, ram_we stays 0, RAM unchanged.
- Back-to-back: SW 0x300 data 0xDEADBEEF, then LW 0x300 presented in the ack cycle -> second request accepted on that edge and returns 0xDEADBEEF.
- Reset mid-RMW: assert rst during WRITE of SB 0x201 -> ram_we drops asynchronously, RAM word unchanged (0x11223344), no rsp_valid; after release, req_ready=1.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data RAM access unit:
// access size encodings, FSM states and the alignment rule.
package mem_pkg;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        WRITE  = 2'b10,
        ERR    = 2'b11
    } mem_state_t;

    // A request is misaligned when a half is on an odd byte, a word is not
    // on a word boundary, or the size code is the reserved one.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            MEM_BYTE: mis = 1'b0;
            MEM_HALF: mis = off[0];
            MEM_WORD: mis = (off != 2'b00);
            default:  mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Bundles the pipeline request/response handshake and the data RAM port.
// Signal suffixes are written from the access unit's point of view.
interface mem_access_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_we_i;
    logic [1:0]        req_size_i;
    logic              req_unsigned_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [DATA_W-1:0] req_wdata_i;
    logic              rsp_valid_o;
    logic [DATA_W-1:0] rsp_rdata_o;
    logic              rsp_misalign_o;
    logic              ram_we_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [DATA_W-1:0] ram_wdata_o;
    logic [DATA_W-1:0] ram_rdata_i;

    // The access unit itself.
    modport slave (
        input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        input  ram_rdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_misalign_o,
        output ram_we_o, ram_addr_o, ram_wdata_o
    );

    // The pipeline plus RAM environment driving the unit.
    modport master (
        output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        output ram_rdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_misalign_o,
        input  ram_we_o, ram_addr_o, ram_wdata_o
    );
endinterface

// File: rtl/mem_lane_align.sv
// Little-endian byte-lane steering for the data RAM: extracts and extends
// load data from a RAM word, and merges sub-word store data into an old word.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] new_i,
    output logic [31:0] load_o,
    output logic [31:0] merged_o
);

    logic [7:0]  loadByte;
    logic [15:0] loadHalf;

    // Pick the addressed lane(s) and sign- or zero-extend to a full word.
    always_comb begin
        loadByte = word_i[{off_i, 3'b000} +: 8];
        loadHalf = word_i[{off_i[1], 4'b0000} +: 16];
        load_o   = word_i;
        case (size_i)
            MEM_BYTE: load_o = {{24{loadByte[7] & ~unsigned_i}}, loadByte};
            MEM_HALF: load_o = {{16{loadHalf[15] & ~unsigned_i}}, loadHalf};
            default:  load_o = word_i;
        endcase
    end

    // Replace the addressed lane(s) of the old word; a full word replaces all.
    always_comb begin
        merged_o = word_i;
        case (size_i)
            MEM_BYTE: merged_o[{off_i, 3'b000} +: 8]     = new_i[7:0];
            MEM_HALF: merged_o[{off_i[1], 4'b0000} +: 16] = new_i[15:0];
            default:  merged_o = new_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for the word-addressed data RAM. Loads take one RAM
// cycle; byte/half stores do a read-modify-write because the RAM only
// writes whole words; misaligned requests are rejected without a RAM access.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic                clk,
    input logic                rst,
    mem_access_unit_if.slave   bus
);

    mem_state_t        state_q, state_d;
    logic              we_q;
    logic [1:0]        size_q;
    logic              unsigned_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              mis_q;
    logic [DATA_W-1:0] merged_q, merged_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_misalign_q, rsp_misalign_d;
    logic              accept;
    logic [31:0]       loadData;
    logic [31:0]       mergedWord;

    mem_lane_align u_align (
        .word_i     (bus.ram_rdata_i),
        .off_i      (addr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (unsigned_q),
        .new_i      (wdata_q),
        .load_o     (loadData),
        .merged_o   (mergedWord)
    );

    assign accept             = bus.req_valid_i && bus.req_ready_o;
    assign bus.req_ready_o    = (state_q == IDLE);
    assign bus.rsp_valid_o    = rsp_valid_q;
    assign bus.rsp_rdata_o    = rsp_rdata_q;
    assign bus.rsp_misalign_o = rsp_misalign_q;

    // RAM port decodes straight from state so reset drops the write strobe at once.
    always_comb begin
        bus.ram_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
        bus.ram_we_o    = 1'b0;
        bus.ram_wdata_o = wdata_q;
        if (state_q == ACCESS && we_q && size_q == MEM_WORD) begin
            bus.ram_we_o = 1'b1;
        end else if (state_q == WRITE) begin
            bus.ram_we_o    = 1'b1;
            bus.ram_wdata_o = merged_q;
        end
    end

    // Next-state and response decode; the response is registered so it lands one cycle later.
    always_comb begin
        state_d        = state_q;
        merged_d       = merged_q;
        rsp_valid_d    = 1'b0;
        rsp_rdata_d    = '0;
        rsp_misalign_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = is_misaligned(bus.req_size_i, bus.req_addr_i[1:0]) ? ERR : ACCESS;
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = loadData;
                    state_d     = IDLE;
                end else if (size_q == MEM_WORD) begin
                    rsp_valid_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    merged_d = mergedWord;
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                rsp_valid_d = 1'b1;
                state_d     = IDLE;
            end
            ERR: begin
                rsp_valid_d    = 1'b1;
                rsp_misalign_d = mis_q;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, captured request and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            we_q           <= 1'b0;
            size_q         <= MEM_BYTE;
            unsigned_q     <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            mis_q          <= 1'b0;
            merged_q       <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_rdata_q    <= '0;
            rsp_misalign_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            merged_q       <= merged_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_rdata_q    <= rsp_rdata_d;
            rsp_misalign_q <= rsp_misalign_d;
            if (accept) begin
                we_q       <= bus.req_we_i;
                size_q     <= bus.req_size_i;
                unsigned_q <= bus.req_unsigned_i;
                addr_q     <= bus.req_addr_i;
                wdata_q    <= bus.req_wdata_i;
                mis_q      <= is_misaligned(bus.req_size_i, bus.req_addr_i[1:0]);
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a driver issues requests and pushes
// hand-computed expectations; a monitor checks every response and RAM write.
module tb_mem_access_unit;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        int          lat;
        int          writes;
        logic [31:0] wword;
        time         acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem [0:1023];
    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          weCount = 0;
    time         t1, t2;

    mem_access_unit_if bus ();

    mem_access_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // 10 ns clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Word RAM model: combinational read, write on the rising edge.
    assign bus.ram_rdata_i = mem[bus.ram_addr_o[11:2]];
    always @(posedge clk) begin
        if (bus.ram_we_o) mem[bus.ram_addr_o[11:2]] <= bus.ram_wdata_o;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Present one request from a falling edge, hold it until accepted, then drop valid.
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] expData, input logic expMis, input int expLat,
                                 input int expWrites, input logic [31:0] expWord,
                                 output time accTime);
        logic rdy;
        bit   accepted;
        exp_t e;
        accepted = 0;
        accTime  = 0;
        @(negedge clk);
        bus.req_valid_i    = 1'b1;
        bus.req_we_i       = we;
        bus.req_size_i     = size;
        bus.req_unsigned_i = uns;
        bus.req_addr_i     = addr;
        bus.req_wdata_i    = wdata;
        for (int i = 0; i < 20 && !accepted; i++) begin
            rdy = bus.req_ready_o;
            @(posedge clk);
            if (rdy) accepted = 1;
            else @(negedge clk);
        end
        checkOutput("request accepted", {31'b0, rdy}, 32'd1);
        accTime  = $time;
        e.rdata  = expData;
        e.mis    = expMis;
        e.lat    = expLat;
        e.writes = expWrites;
        e.wword  = expWord;
        e.acc    = accTime;
        if (accepted) sb.push_back(e);
        #1 bus.req_valid_i = 1'b0;
    endtask

    // Wait (bounded) until every expected response has been seen.
    task automatic waitDone();
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        #1;
        checkOutput("pending responses", sb.size(), 32'd0);
        sb.delete();
    endtask

    // Monitor: checks RAM writes against the current transaction and scores each response.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            weCount = 0;
        end else begin
            if (bus.ram_we_o) begin
                weCount++;
                if (sb.size() == 0) checkOutput("unexpected ram_we", {31'b0, bus.ram_we_o}, 32'd0);
                else checkOutput("ram_wdata", bus.ram_wdata_o, sb[0].wword);
            end
            if (bus.rsp_valid_o) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected rsp_valid", {31'b0, bus.rsp_valid_o}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("rsp_rdata", bus.rsp_rdata_o, e.rdata);
                    checkOutput("rsp_misalign", {31'b0, bus.rsp_misalign_o}, {31'b0, e.mis});
                    checkOutput("latency", 32'(($time - e.acc + 5) / 10), 32'(e.lat));
                    checkOutput("ram_we pulses", 32'(weCount), 32'(e.writes));
                    checkOutput("req_ready with rsp", {31'b0, bus.req_ready_o}, 32'd1);
                end
                weCount = 0;
            end
        end
    end

    initial begin
        bus.req_valid_i    = 1'b0;
        bus.req_we_i       = 1'b0;
        bus.req_size_i     = 2'b00;
        bus.req_unsigned_i = 1'b0;
        bus.req_addr_i     = '0;
        bus.req_wdata_i    = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[32'h1_0000 >> 2 & 1023] = 32'h0062_6261;
        mem[32'h100 >> 2] = 32'h8061_7F62;
        mem[32'h200 >> 2] = 32'h1122_3344;

        #2;
        checkOutput("reset req_ready", {31'b0, bus.req_ready_o}, 32'd1);
        checkOutput("reset rsp_valid", {31'b0, bus.rsp_valid_o}, 32'd0);
        checkOutput("reset rsp_rdata", bus.rsp_rdata_o, 32'd0);
        checkOutput("reset rsp_misalign", {31'b0, bus.rsp_misalign_o}, 32'd0);
        checkOutput("reset ram_we", {31'b0, bus.ram_we_o}, 32'd0);
        checkOutput("reset ram_addr", bus.ram_addr_o, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] loads");
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h0001_0000, 32'h0, 32'h0062_6261, 1'b0, 2, 0, 32'h0, t1);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'hFFFF_FF80, 1'b0, 2, 0, 32'h0, t1);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h0000_0080, 1'b0, 2, 0, 32'h0, t1);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'hFFFF_8061, 1'b0, 2, 0, 32'h0, t1);
        applyStimulus(1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 32'h0000_7F62, 1'b0, 2, 0, 32'h0, t1);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 32'h0000_007F, 1'b0, 2, 0, 32'h0, t1);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h100, 32'h0, 32'h0000_7F62, 1'b0, 2, 0, 32'h0, t1);
        waitDone();

        $display("[TB] sub-word stores");
        applyStimulus(1'b1, 2'b00, 1'b0, 32'h201, 32'h0000_00AB, 32'h0, 1'b0, 3, 1, 32'h1122_AB44, t1);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 32'h1122_AB44, 1'b0, 2, 0, 32'h0, t1);
        waitDone();
        mem[32'h200 >> 2] = 32'h1122_3344;
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000_5566, 32'h0, 1'b0, 3, 1, 32'h5566_3344, t1);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 32'h5566_3344, 1'b0, 2, 0, 32'h0, t1);
        waitDone();

        $display("[TB] misaligned");
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h0, 1'b1, 2, 0, 32'h0, t1);
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h203, 32'h0000_9999, 32'h0, 1'b1, 2, 0, 32'h0, t1);
        applyStimulus(1'b1, 2'b11, 1'b0, 32'h100, 32'h1234_5678, 32'h0, 1'b1, 2, 0, 32'h0, t1);
        waitDone();
        checkOutput("RAM 0x100 untouched", mem[32'h100 >> 2], 32'h8061_7F62);
        checkOutput("RAM 0x200 untouched", mem[32'h200 >> 2], 32'h5566_3344);

        $display("[TB] back-to-back");
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h300, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 1, 32'hDEAD_BEEF, t1);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 0, 32'h0, t2);
        waitDone();
        checkOutput("back-to-back accept gap", 32'(t2 - t1), 32'd20);

        $display("[TB] reset during RMW write");
        mem[32'h200 >> 2] = 32'h1122_3344;
        applyStimulus(1'b1, 2'b00, 1'b0, 32'h201, 32'h0000_00AB, 32'h0, 1'b0, 3, 1, 32'h1122_AB44, t1);
        @(posedge clk);
        #2;
        checkOutput("RMW write strobe", {31'b0, bus.ram_we_o}, 32'd1);
        checkOutput("RMW merged word", bus.ram_wdata_o, 32'h1122_AB44);
        rst = 1'b1;
        #1;
        sb.delete();
        checkOutput("ram_we after async reset", {31'b0, bus.ram_we_o}, 32'd0);
        checkOutput("rsp_valid after async reset", {31'b0, bus.rsp_valid_o}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("RAM word after abandoned RMW", mem[32'h200 >> 2], 32'h1122_3344);
        checkOutput("req_ready after reset", {31'b0, bus.req_ready_o}, 32'd1);
        repeat (4) @(negedge clk);
        #1;
        checkOutput("RAM word stays intact", mem[32'h200 >> 2], 32'h1122_3344);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
